// File: rtl/mig_tt_sequencer.sv
// mig_tt_sequencer
// Computes the 16-bit truth table of a 4-input majority-inverter network.
// Gates live in a small config RAM and are evaluated one per cycle on a
// shared MAJ3 unit, for each input minterm m = 0..15 in turn.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   cfg_we/addr/data    gate slot write {inv_c,idx_c,inv_b,idx_b,inv_a,idx_a};
//                       ignored while busy
//   num_gates           gates to evaluate (clamped to MAX_GATES), sampled on start
//   out_sel, out_inv    result node and complement, sampled on start
//   start               begin a run when not busy
//   busy                run in progress
//   done                one-cycle pulse, tt valid
//   tt                  truth table, bit m = f(x3..x0 = m)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, tt held
// S_EVAL  | evaluating gate g for minterm m
// S_STORE | writing tt[m] from the selected node, clearing node regs
// S_DONE  | last minterm stored; done pulses on leaving this state
module mig_tt_sequencer #(
  parameter int MAX_GATES = 8,
  parameter int GA_W      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [GA_W-1:0] cfg_addr,
  input  logic [14:0]     cfg_data,
  input  logic [3:0]      num_gates,
  input  logic [3:0]      out_sel,
  input  logic            out_inv,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [15:0]     tt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state;
  logic [3:0]           m;
  logic [3:0]           g;
  logic [3:0]           gcnt;
  logic [3:0]           sel_q;
  logic                 inv_q;
  logic [MAX_GATES-1:0] node;
  logic [14:0]          ram [MAX_GATES];

  logic                 accept;
  logic [3:0]           g_clamp;
  logic [14:0]          gate_word;
  logic                 op_a, op_b, op_c, gate_out, out_bit;
  logic [MAX_GATES-1:0] g_onehot;

  // Node 0 is constant 0, nodes 1..4 are x0..x3 taken from the minterm,
  // nodes 5.. are gate registers. Unwritten gates read 0 because the
  // registers are cleared for every minterm, which also makes forward and
  // self references read 0.
  function automatic logic node_val(input logic [3:0] idx, input logic [3:0] mm,
                                    input logic [MAX_GATES-1:0] nd);
    logic [MAX_GATES-1:0] sh;
    logic                 r;
    sh = nd >> (idx - 4'd5);
    if (idx == 4'd0)                          r = 1'b0;
    else if (idx <= 4'd4)                     r = mm[idx[1:0] - 2'd1];
    else if (32'(idx) <= 32'(4 + MAX_GATES))  r = sh[0];
    else                                      r = 1'b0;
    return r;
  endfunction

  always_comb begin
    accept    = start && !busy && (state == S_IDLE || state == S_DONE);
    g_clamp   = (32'(num_gates) > 32'(MAX_GATES)) ? 4'(MAX_GATES) : num_gates;
    gate_word = ram[g[GA_W-1:0]];
    op_a      = node_val(gate_word[3:0], m, node) ^ gate_word[4];
    op_b      = node_val(gate_word[8:5], m, node) ^ gate_word[9];
    op_c      = node_val(gate_word[13:10], m, node) ^ gate_word[14];
    gate_out  = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
    g_onehot  = MAX_GATES'(1) << g;
    out_bit   = node_val(sel_q, m, node) ^ inv_q;
  end

  // Config RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy && (32'(cfg_addr) < 32'(MAX_GATES)))
      ram[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      tt    <= '0;
      m     <= '0;
      g     <= '0;
      gcnt  <= '0;
      sel_q <= '0;
      inv_q <= 1'b0;
      node  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: ;
        S_EVAL: begin
          if (gate_out) node <= node | g_onehot;
          g <= g + 4'd1;
          if (g == gcnt - 4'd1) state <= S_STORE;
        end
        S_STORE: begin
          tt[m] <= out_bit;
          node  <= '0;
          g     <= '0;
          if (m == 4'd15) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end else begin
            m     <= m + 4'd1;
            state <= (gcnt == 4'd0) ? S_STORE : S_EVAL;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A start in the DONE cycle overrides the return to IDLE but the
      // done pulse above still fires.
      if (accept) begin
        busy  <= 1'b1;
        tt    <= '0;
        m     <= '0;
        g     <= '0;
        node  <= '0;
        gcnt  <= g_clamp;
        sel_q <= out_sel;
        inv_q <= out_inv;
        state <= (g_clamp == 4'd0) ? S_STORE : S_EVAL;
      end
    end
  end

endmodule
